// File: rtl/bcd_updown_counter.sv
// Multi-digit BCD up/down counter: load, wrap or saturate, cascadable tc.
// Define BCD_COUNTER_LOAD_CHECK_EN to reject loads with nibbles >9 and flag err.
module bcd_updown_counter #(
  parameter int DIGITS = 2,
  parameter int WRAP   = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en,
  input  logic                  up,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_val,
  output logic [4*DIGITS-1:0]   count,
  output logic                  tc,
  output logic                  zero,
  output logic                  err
);

  localparam int W = 4 * DIGITS;
  localparam logic [W-1:0] ALL9 = {DIGITS{4'h9}};

  logic [W-1:0]      count_q;
  logic [W-1:0]      step_val;
  logic [W-1:0]      load_fix;
  logic [DIGITS-1:0] nib_bad;
  logic [3:0]        d;
  logic              ripple;
  logic              at_end;
  logic              hold_end;

  // ripple is the carry (up) or borrow (down) entering each digit
  always_comb begin
    step_val = count_q;
    ripple   = 1'b1;
    d        = 4'h0;
    for (int i = 0; i < DIGITS; i++) begin
      d = count_q[4*i +: 4];
      if (ripple) begin
        if (up)
          step_val[4*i +: 4] = (d == 4'd9) ? 4'd0 : d + 4'd1;
        else
          step_val[4*i +: 4] = (d == 4'd0) ? 4'd9 : d - 4'd1;
      end
      ripple = ripple & (up ? (d == 4'd9) : (d == 4'd0));
    end
    at_end = ripple;
  end

  always_comb begin
    load_fix = load_val;
    nib_bad  = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (load_val[4*i +: 4] > 4'd9) begin
        nib_bad[i]         = 1'b1;
        load_fix[4*i +: 4] = 4'd9;
      end
    end
  end

  assign hold_end = at_end && (WRAP == 0);

`ifdef BCD_COUNTER_LOAD_CHECK_EN
  logic load_bad;
  logic err_q;

  assign load_bad = |nib_bad;

  always_ff @(posedge clk) begin
    if (reset)
      count_q <= '0;
    else if (load) begin
      if (!load_bad)
        count_q <= load_fix;
    end else if (en && !hold_end)
      count_q <= step_val;
  end

  always_ff @(posedge clk) begin
    if (reset)
      err_q <= 1'b0;
    else if (load && load_bad)
      err_q <= 1'b1;
  end

  assign err = err_q;
`else
  // out-of-range nibbles were already clamped to 9 in load_fix
  always_ff @(posedge clk) begin
    if (reset)
      count_q <= '0;
    else if (load)
      count_q <= load_fix;
    else if (en && !hold_end)
      count_q <= step_val;
  end

  assign err = 1'b0;
`endif

  assign count = count_q;
  assign zero  = (count_q == '0);
  assign tc    = en & (up ? (count_q == ALL9)
                          : (count_q == '0));

endmodule

// File: tb/tb_bcd_updown_counter.sv
// Randomized self-checking bench for bcd_updown_counter.
// Reference model keeps each count as a plain decimal integer.
module tb_bcd_updown_counter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, en, up, load;
  logic [7:0] load_val;
  logic [7:0] c0, c1;
  logic [3:0] c2;
  logic       tc0, tc1, tc2, z0, z1, z2, e0, e1, e2;

  logic        ch_reset, ch_en, ch_up, ch_load;
  logic [15:0] ch_val;
  logic [7:0]  lo_cnt, hi_cnt;
  logic        lo_tc, hi_tc, lo_z, hi_z, lo_e, hi_e;

  bcd_updown_counter #(.DIGITS(2), .WRAP(1)) dut_w (
    .clk(clk), .reset(reset), .en(en), .up(up), .load(load),
    .load_val(load_val), .count(c0), .tc(tc0), .zero(z0), .err(e0));

  bcd_updown_counter #(.DIGITS(2), .WRAP(0)) dut_s (
    .clk(clk), .reset(reset), .en(en), .up(up), .load(load),
    .load_val(load_val), .count(c1), .tc(tc1), .zero(z1), .err(e1));

  bcd_updown_counter #(.DIGITS(1), .WRAP(1)) dut_1 (
    .clk(clk), .reset(reset), .en(en), .up(up), .load(load),
    .load_val(load_val[3:0]), .count(c2), .tc(tc2), .zero(z2),
    .err(e2));

  bcd_updown_counter #(.DIGITS(2), .WRAP(1)) dut_lo (
    .clk(clk), .reset(ch_reset), .en(ch_en), .up(ch_up),
    .load(ch_load), .load_val(ch_val[7:0]), .count(lo_cnt),
    .tc(lo_tc), .zero(lo_z), .err(lo_e));

  bcd_updown_counter #(.DIGITS(2), .WRAP(1)) dut_hi (
    .clk(clk), .reset(ch_reset), .en(lo_tc), .up(ch_up),
    .load(ch_load), .load_val(ch_val[15:8]), .count(hi_cnt),
    .tc(hi_tc), .zero(hi_z), .err(hi_e));

`ifdef BCD_COUNTER_LOAD_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  int checks = 0;
  int errors = 0;

  int dg[3] = '{2, 2, 1};
  int wr[3] = '{1, 0, 1};
  int mv[3] = '{0, 0, 0};
  bit merr[3] = '{1'b0, 1'b0, 1'b0};

  function automatic int maxv(input int nd);
    int m = 1;
    repeat (nd) m = m * 10;
    return m - 1;
  endfunction

  function automatic logic [31:0] to_bcd(input int v, input int nd);
    logic [31:0] r = '0;
    int x = v;
    for (int k = 0; k < nd; k++) begin
      r[4*k +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  function automatic logic [31:0] act_count(input int i);
    case (i)
      0: return {24'b0, c0};
      1: return {24'b0, c1};
      default: return {28'b0, c2};
    endcase
  endfunction

  function automatic logic act_tc(input int i);
    case (i)
      0: return tc0;
      1: return tc1;
      default: return tc2;
    endcase
  endfunction

  function automatic logic act_zero(input int i);
    case (i)
      0: return z0;
      1: return z1;
      default: return z2;
    endcase
  endfunction

  function automatic logic act_err(input int i);
    case (i)
      0: return e0;
      1: return e1;
      default: return e2;
    endcase
  endfunction

  function automatic logic exp_tc(input int i);
    if (!en) return 1'b0;
    return up ? (mv[i] == maxv(dg[i])) : (mv[i] == 0);
  endfunction

  task automatic model_edge();
    for (int i = 0; i < 3; i++) begin
      int mx = maxv(dg[i]);
      if (reset) begin
        mv[i] = 0;
        merr[i] = 1'b0;
      end else if (load) begin
        int val = 0;
        int mul = 1;
        bit bad = 1'b0;
        for (int k = 0; k < dg[i]; k++) begin
          int n = int'(load_val[4*k +: 4]);
          if (n > 9) begin
            bad = 1'b1;
            n = 9;
          end
          val = val + n * mul;
          mul = mul * 10;
        end
        if (CHK && bad) merr[i] = 1'b1;
        else mv[i] = val;
      end else if (en) begin
        if (up) mv[i] = (mv[i] == mx) ? ((wr[i] != 0) ? 0 : mx) : mv[i] + 1;
        else mv[i] = (mv[i] == 0) ? ((wr[i] != 0) ? mx : 0) : mv[i] - 1;
      end
    end
  endtask

  task automatic drive(input logic r, input logic e, input logic u,
                       input logic l, input logic [7:0] v);
    reset = r;
    en = e;
    up = u;
    load = l;
    load_val = v;
  endtask

  task automatic clk_edge();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    drive(1'b1, 1'b1, 1'b1, 1'b0, 8'h00);
    clk_edge();
    clk_edge();
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (act_count(i) !== 32'h0) begin
        errors++;
        $display("FAIL reset_count inst%0d got %h want 0", i, act_count(i));
      end
      checks++;
      if (act_zero(i) !== 1'b1 || act_err(i) !== 1'b0) begin
        errors++;
        $display("FAIL reset_flags inst%0d got zero=%b err=%b want 1 0",
                 i, act_zero(i), act_err(i));
      end
      checks++;
      if (act_tc(i) !== 1'b0) begin
        errors++;
        $display("FAIL reset_tc inst%0d got %b want 0", i, act_tc(i));
      end
    end
  endtask

  task automatic test_up_sweep();
    drive(1'b0, 1'b1, 1'b1, 1'b0, 8'h00);
    for (int n = 0; n < 100; n++) begin
      #1;
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (act_tc(i) !== exp_tc(i)) begin
          errors++;
          $display("FAIL up_tc inst%0d step%0d got %b want %b",
                   i, n, act_tc(i), exp_tc(i));
        end
      end
      clk_edge();
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (act_count(i) !== to_bcd(mv[i], dg[i])) begin
          errors++;
          $display("FAIL up_count inst%0d step%0d got %h want %h",
                   i, n, act_count(i), to_bcd(mv[i], dg[i]));
        end
      end
    end
    checks++;
    if (c0 !== 8'h00 || c1 !== 8'h99) begin
      errors++;
      $display("FAIL up_end got wrap=%h sat=%h want 00 99", c0, c1);
    end
  endtask

  task automatic test_down_wrap();
    drive(1'b0, 1'b0, 1'b0, 1'b1, 8'h10);
    clk_edge();
    drive(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    clk_edge();
    checks++;
    if (c0 !== 8'h09 || c1 !== 8'h09) begin
      errors++;
      $display("FAIL down_borrow got %h %h want 09 09", c0, c1);
    end
    drive(1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
    clk_edge();
    drive(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    #1;
    checks++;
    if (tc0 !== 1'b1 || tc1 !== 1'b1 || tc2 !== 1'b1) begin
      errors++;
      $display("FAIL down_tc got %b%b%b want 111", tc0, tc1, tc2);
    end
    clk_edge();
    checks++;
    if (c0 !== 8'h99 || c1 !== 8'h00 || c2 !== 4'h9) begin
      errors++;
      $display("FAIL down_end got %h %h %h want 99 00 9", c0, c1, c2);
    end
    checks++;
    if (tc1 !== 1'b1 || tc0 !== 1'b0) begin
      errors++;
      $display("FAIL down_tc_after got sat=%b wrap=%b want 1 0", tc1, tc0);
    end
  endtask

  task automatic test_load_priority();
    drive(1'b0, 1'b1, 1'b1, 1'b1, 8'h57);
    clk_edge();
    checks++;
    if (c0 !== 8'h57 || c1 !== 8'h57 || c2 !== 4'h7) begin
      errors++;
      $display("FAIL load_prio got %h %h %h want 57 57 7", c0, c1, c2);
    end
    drive(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
    for (int n = 0; n < 5; n++) begin
      clk_edge();
      checks++;
      if (c0 !== 8'h57 || c1 !== 8'h57) begin
        errors++;
        $display("FAIL hold cycle%0d got %h %h want 57", n, c0, c1);
      end
    end
    drive(1'b1, 1'b1, 1'b1, 1'b1, 8'h57);
    clk_edge();
    checks++;
    if (c0 !== 8'h00 || c1 !== 8'h00 || c2 !== 4'h0) begin
      errors++;
      $display("FAIL reset_prio got %h %h %h want 00", c0, c1, c2);
    end
  endtask

  task automatic test_invalid_load();
    drive(1'b0, 1'b0, 1'b1, 1'b1, 8'h3C);
    clk_edge();
    checks++;
    if (c0 !== (CHK ? 8'h00 : 8'h39) || e0 !== CHK) begin
      errors++;
      $display("FAIL bad_load got %h err=%b want %h err=%b",
               c0, e0, CHK ? 8'h00 : 8'h39, CHK);
    end
    drive(1'b0, 1'b0, 1'b1, 1'b1, 8'h12);
    clk_edge();
    checks++;
    if (c0 !== 8'h12 || e0 !== CHK) begin
      errors++;
      $display("FAIL good_load got %h err=%b want 12 err=%b", c0, e0, CHK);
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (act_count(i) !== to_bcd(mv[i], dg[i]) || act_err(i) !== merr[i]) begin
        errors++;
        $display("FAIL load_model inst%0d got %h/%b want %h/%b", i,
                 act_count(i), act_err(i), to_bcd(mv[i], dg[i]), merr[i]);
      end
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      logic [7:0] v;
      v = ($urandom_range(3) == 0) ?
          (($urandom_range(1) == 1) ? 8'h99 : 8'h00) : 8'($urandom);
      drive(($urandom_range(31) == 0), ($urandom_range(3) != 0),
            1'($urandom_range(1)), ($urandom_range(7) == 0), v);
      #1;
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (act_tc(i) !== exp_tc(i) || act_zero(i) !== (mv[i] == 0)) begin
          errors++;
          $display("FAIL rand_comb inst%0d cyc%0d got tc=%b z=%b want %b %b",
                   i, n, act_tc(i), act_zero(i), exp_tc(i), mv[i] == 0);
        end
      end
      clk_edge();
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (act_count(i) !== to_bcd(mv[i], dg[i]) || act_err(i) !== merr[i]) begin
          errors++;
          $display("FAIL rand_seq inst%0d cyc%0d got %h/%b want %h/%b", i, n,
                   act_count(i), act_err(i), to_bcd(mv[i], dg[i]), merr[i]);
        end
      end
    end
  endtask

  task automatic test_cascade();
    int cv = 0;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    ch_reset = 1'b0;
    ch_en = 1'b0;
    ch_up = 1'b1;
    ch_load = 1'b1;
    ch_val = 16'h0099;
    @(posedge clk);
    #1;
    ch_load = 1'b0;
    ch_en = 1'b1;
    #1;
    checks++;
    if (lo_tc !== 1'b1) begin
      errors++;
      $display("FAIL cascade_tc got %b want 1", lo_tc);
    end
    @(posedge clk);
    #1;
    checks++;
    if ({hi_cnt, lo_cnt} !== 16'h0100) begin
      errors++;
      $display("FAIL cascade_carry got %h want 0100", {hi_cnt, lo_cnt});
    end
    cv = 100;
    for (int n = 0; n < 300; n++) begin
      ch_reset = ($urandom_range(63) == 0);
      ch_load = ($urandom_range(15) == 0);
      ch_en = ($urandom_range(7) != 0);
      ch_up = 1'($urandom_range(1));
      case ($urandom_range(3))
        0: ch_val = 16'h9999;
        1: ch_val = 16'h0000;
        2: ch_val = 16'h0099;
        default: ch_val = 16'h9900;
      endcase
      if (ch_reset) cv = 0;
      else if (ch_load)
        cv = (ch_val == 16'h9999) ? 9999 : (ch_val == 16'h0099) ? 99 :
             (ch_val == 16'h9900) ? 9900 : 0;
      else if (ch_en) cv = ch_up ? (cv + 1) % 10000 : (cv + 9999) % 10000;
      @(posedge clk);
      #1;
      checks++;
      if ({hi_cnt, lo_cnt} !== to_bcd(cv, 4)) begin
        errors++;
        $display("FAIL cascade_rand cyc%0d got %h want %h", n,
                 {hi_cnt, lo_cnt}, to_bcd(cv, 4));
      end
    end
  endtask

  initial begin
    ch_reset = 1'b1;
    ch_en = 1'b0;
    ch_up = 1'b1;
    ch_load = 1'b0;
    ch_val = 16'h0000;
    drive(1'b1, 1'b1, 1'b1, 1'b0, 8'h00);
    @(negedge clk);
    test_reset();
    ch_reset = 1'b0;
    test_up_sweep();
    test_down_wrap();
    test_load_priority();
    test_invalid_load();
    test_random();
    test_cascade();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
